ex_mem_skid_stage: RTL and testbench
====================================

Name: ex_mem_skid_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the ALU.
- Captures the ALU result, store data, destination register and memory/writeback control bits, then presents them to the memory stage over a valid/ready handshake.
- A 2-entry skid buffer gives a registered in_ready, so memory-stage back-pressure never builds a combinational path back into execute.
- Provides operand-forwarding outputs from the head entry and a saturating stall-cycle counter.

Parameters:
DATA_WIDTH, 32, width of ALU result and store data
REG_ADDR_WIDTH, 5, width of destination register index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous clear of both entries (branch/exception squash)
in_valid  input  1  execute stage presents a beat
in_ready  output  1  stage can accept a beat; registered, equals NOT skid_valid
in_result  input  DATA_WIDTH  ALU Result
in_store_data  input  DATA_WIDTH  register B value for stores
in_dest  input  REG_ADDR_WIDTH  destination register index
in_reg_write  input  1  writeback enable
in_mem_read  input  1  load
in_mem_write  input  1  store
out_valid  output  1  head entry valid
out_ready  input  1  memory stage accepts head
out_result  output  DATA_WIDTH  head result
out_store_data  output  DATA_WIDTH  head store data
out_dest  output  REG_ADDR_WIDTH  head destination
out_reg_write  output  1  head writeback enable
out_mem_read  output  1  head load
out_mem_write  output  1  head store
fwd_valid  output  1  head_valid AND out_reg_write AND out_dest != 0 AND NOT out_mem_read
fwd_dest  output  REG_ADDR_WIDTH  equals out_dest
fwd_data  output  DATA_WIDTH  equals out_result
occupancy  output  2  number of valid entries, 0..2
stall_cycles  output  32  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: head entry H drives all out_* ports; skid entry S holds one overflow beat. Each entry stores all payload fields plus a valid bit.
- Reset, asynchronous: H_valid=0, S_valid=0, every payload field 0, stall_cycles=0, occupancy=0, out_valid=0, fwd_valid=0. in_ready reads 1 while reset is held and after release.
- Handshakes: accept = in_valid AND in_ready; pop = out_valid AND out_ready. Payload inputs are ignored when accept=0.
- Next state, evaluated per edge when flush=0:
  - H empty or pop, S valid: H<=S, S cleared. in_ready was 0, so no accept can occur.
  - H empty or pop, S empty, accept: H<=input.
  - H empty or pop, S empty, no accept: H_valid<=0.
  - H full, no pop, accept: S<=input; in_ready goes 0 the next cycle.
  - H full, no pop, no accept: hold.
- Latency: an accepted beat appears on out_* one cycle after accept when H is free, and is never combinationally bypassed. With continuous out_ready=1 the stage sustains 1 beat per cycle.
- Ordering: strictly FIFO. The S beat always leaves before any newer beat.
- Flush, synchronous, priority over all other updates: H_valid<=0 and S_valid<=0. An accept or pop in the same cycle is discarded; the upstream beat is lost by design. Payload registers may hold stale data. in_ready=1 the cycle after.
- out_* payload ports show the H payload regardless of H_valid; consumers qualify them with out_valid.
- occupancy = H_valid + S_valid. Invariant: S_valid implies H_valid; a violation is an assertion failure.
- stall_cycles increments on each edge where out_valid=1 and out_ready=0. It holds at 0xFFFFFFFF. It is not cleared by flush, only by reset.
- Reset asserted mid-transfer clears everything immediately, without waiting for a clock edge.

Test Plan:
- Streaming: out_ready=1; accept in_result 0x1, 0x2, 0x3 on consecutive cycles -> out_result 0x1, 0x2, 0x3 on the following 3 cycles; occupancy never exceeds 1; stall_cycles=0.
- Back-pressure: out_ready=0; send 0xA then 0xB -> in_ready=0 after second accept, occupancy=2; raise out_ready -> 0xA, then 0xB, then in_ready=1; stall_cycles equals the number of cycles out_ready was held low with out_valid=1.
- Flush: occupancy=2, assert flush with in_valid=1 and in_result 0xC -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xC never appears.
- Forwarding: head with in_dest=5, reg_write=1, result 0x1234 -> fwd_valid=1, fwd_dest=5, fwd_data=0x1234; repeat with dest=0 or mem_read=1 -> fwd_valid=0.
- Async reset: assert reset mid-cycle with occupancy=2 and stall_cycles=7 -> all outputs go to reset values before the next edge; in_ready=1.
- Saturation: force stall_cycles to 0xFFFFFFFE, hold a stall for 3 cycles -> counter reads 0xFFFFFFFF and stays there.

Source files
------------

// File: rtl/ex_mem_skid_stage.sv
// Execute-to-memory pipeline register with a 2-entry skid buffer, head-entry operand
// forwarding and a saturating stall-cycle counter.

module ex_mem_skid_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [DATA_WIDTH-1:0]     in_store_data,
    input  logic [REG_ADDR_WIDTH-1:0] in_dest,
    input  logic                      in_reg_write,
    input  logic                      in_mem_read,
    input  logic                      in_mem_write,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [REG_ADDR_WIDTH-1:0] out_dest,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_dest,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic [1:0]                occupancy,
    output logic [31:0]               stall_cycles
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic [DATA_WIDTH-1:0]     store_data;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic                      reg_write;
        logic                      mem_read;
        logic                      mem_write;
    } entry_t;

    localparam entry_t ENTRY_ZERO = '{
        result:     {DATA_WIDTH{1'b0}},
        store_data: {DATA_WIDTH{1'b0}},
        dest:       {REG_ADDR_WIDTH{1'b0}},
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0
    };

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

    entry_t      h_r, s_r, h_s, s_s, in_entry_s;
    logic        h_valid_r, s_valid_r, h_valid_s, s_valid_s;
    logic        in_ready_r, fwd_valid_r, fwd_valid_s;
    logic [1:0]  occupancy_r, occupancy_s;
    logic [31:0] stall_cycles_r, stall_cycles_s;
    logic        accept_s, pop_s;

    // Handshakes and next-state selection for head and skid entries.
    always_comb begin
        in_entry_s = '{
            result:     in_result,
            store_data: in_store_data,
            dest:       in_dest,
            reg_write:  in_reg_write,
            mem_read:   in_mem_read,
            mem_write:  in_mem_write
        };
        accept_s  = in_valid & in_ready_r;
        pop_s     = h_valid_r & out_ready;
        h_s       = h_r;
        s_s       = s_r;
        h_valid_s = h_valid_r;
        s_valid_s = s_valid_r;
        if (flush) begin
            h_valid_s = 1'b0;
            s_valid_s = 1'b0;
        end else if (!h_valid_r || pop_s) begin
            // Skid beat is older than anything upstream, so it always refills the head first.
            if (s_valid_r) begin
                h_s       = s_r;
                h_valid_s = 1'b1;
                s_valid_s = 1'b0;
            end else if (accept_s) begin
                h_s       = in_entry_s;
                h_valid_s = 1'b1;
            end else begin
                h_valid_s = 1'b0;
            end
        end else if (accept_s) begin
            s_s       = in_entry_s;
            s_valid_s = 1'b1;
        end else begin
            h_valid_s = h_valid_r;
            s_valid_s = s_valid_r;
        end
    end

    // Derived outputs are computed from next state so they leave the block as flops.
    always_comb begin
        fwd_valid_s = h_valid_s & h_s.reg_write & ~h_s.mem_read &
                      (h_s.dest != {REG_ADDR_WIDTH{1'b0}});
        occupancy_s = {1'b0, h_valid_s} + {1'b0, s_valid_s};
        if (h_valid_r && !out_ready) begin
            stall_cycles_s = sat_inc(stall_cycles_r);
        end else begin
            stall_cycles_s = stall_cycles_r;
        end
    end

    // State registers; stall counter survives flush and is cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_r            <= ENTRY_ZERO;
            s_r            <= ENTRY_ZERO;
            h_valid_r      <= 1'b0;
            s_valid_r      <= 1'b0;
            in_ready_r     <= 1'b1;
            fwd_valid_r    <= 1'b0;
            occupancy_r    <= 2'd0;
            stall_cycles_r <= 32'd0;
        end else begin
            h_r            <= h_s;
            s_r            <= s_s;
            h_valid_r      <= h_valid_s;
            s_valid_r      <= s_valid_s;
            in_ready_r     <= ~s_valid_s;
            fwd_valid_r    <= fwd_valid_s;
            occupancy_r    <= occupancy_s;
            stall_cycles_r <= stall_cycles_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = h_valid_r;
    assign out_result     = h_r.result;
    assign out_store_data = h_r.store_data;
    assign out_dest       = h_r.dest;
    assign out_reg_write  = h_r.reg_write;
    assign out_mem_read   = h_r.mem_read;
    assign out_mem_write  = h_r.mem_write;
    assign fwd_valid      = fwd_valid_r;
    assign fwd_dest       = h_r.dest;
    assign fwd_data       = h_r.result;
    assign occupancy      = occupancy_r;
    assign stall_cycles   = stall_cycles_r;

    ex_mem_skid_stage_checker u_checker (
        .clk       (clk),
        .reset     (reset),
        .h_valid   (h_valid_r),
        .s_valid   (s_valid_r),
        .occupancy (occupancy_r),
        .in_ready  (in_ready_r)
    );

endmodule

// Structural invariants of the skid buffer.
module ex_mem_skid_stage_checker (
    input logic       clk,
    input logic       reset,
    input logic       h_valid,
    input logic       s_valid,
    input logic [1:0] occupancy,
    input logic       in_ready
);

    a_skid_implies_head: assert property (@(posedge clk) disable iff (reset)
        s_valid |-> h_valid);

    a_occupancy_consistent: assert property (@(posedge clk) disable iff (reset)
        occupancy == ({1'b0, h_valid} + {1'b0, s_valid}));

    a_ready_is_not_skid: assert property (@(posedge clk) disable iff (reset)
        in_ready == !s_valid);

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Vector table plus scoreboard bench for ex_mem_skid_stage: a queue models the FIFO
// contents, and hand sequences cover asynchronous reset and counter saturation.

module tb_ex_mem_skid_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_result, in_store_data, out_result, out_store_data, fwd_data, stall_cycles;
    logic [4:0]  in_dest, out_dest, fwd_dest;
    logic        in_reg_write, in_mem_read, in_mem_write;
    logic        out_reg_write, out_mem_read, out_mem_write, fwd_valid;
    logic [1:0]  occupancy;

    always #5 clk = ~clk;

    ex_mem_skid_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data), .in_dest(in_dest),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  dest;
        logic        rw, mr, mw;
    } beat_t;

    typedef struct {
        logic        iv;
        logic [31:0] res;
        logic [4:0]  dest;
        logic        rw, mr, mw, ordy, fl;
        int          exp_occ;
        logic        exp_fwd;
    } vec_t;

    beat_t       sb[$];
    vec_t        vt[24];
    logic [31:0] exp_stall;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input vec_t v);
        beat_t b;
        b.result     = v.res;
        b.store_data = v.res ^ 32'hA5A5_0F0F;
        b.dest       = v.dest;
        b.rw         = v.rw;
        b.mr         = v.mr;
        b.mw         = v.mw;
        return b;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'(sb.size()));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(sb.size() < 2));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(sb.size() > 0));
        chk({tag, "_stall"}, 64'(stall_cycles), 64'(exp_stall));
        if (sb.size() > 0) begin
            chk({tag, "_out_result"}, 64'(out_result), 64'(sb[0].result));
            chk({tag, "_out_store"}, 64'(out_store_data), 64'(sb[0].store_data));
            chk({tag, "_out_dest"}, 64'(out_dest), 64'(sb[0].dest));
            chk({tag, "_out_ctl"}, 64'({out_reg_write, out_mem_read, out_mem_write}),
                64'({sb[0].rw, sb[0].mr, sb[0].mw}));
            chk({tag, "_fwd_dest"}, 64'(fwd_dest), 64'(sb[0].dest));
            chk({tag, "_fwd_data"}, 64'(fwd_data), 64'(sb[0].result));
            chk({tag, "_fwd_valid"}, 64'(fwd_valid),
                64'(sb[0].rw && (sb[0].dest != 5'd0) && !sb[0].mr));
        end else begin
            chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
        end
    endtask

    // Drives one cycle at the negedge, updates the model, returns at the next negedge.
    task automatic drive(input logic iv, input beat_t b, input logic ordy, input logic fl);
        logic  acc, pop;
        beat_t gone;
        in_valid      = iv;
        in_result     = b.result;
        in_store_data = b.store_data;
        in_dest       = b.dest;
        in_reg_write  = b.rw;
        in_mem_read   = b.mr;
        in_mem_write  = b.mw;
        out_ready     = ordy;
        flush         = fl;
        acc = iv && (sb.size() < 2);
        pop = (sb.size() > 0) && ordy;
        if ((sb.size() > 0) && !ordy && (exp_stall != 32'hFFFF_FFFF)) exp_stall = exp_stall + 32'd1;
        if (fl) begin
            sb.delete();
        end else begin
            if (pop) gone = sb.pop_front();
            if (acc) sb.push_back(b);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        chk({tag, "_stall"}, 64'(stall_cycles), 64'd0);
        chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
        chk({tag, "_payload"}, 64'(out_result | out_store_data | 32'(out_dest)), 64'd0);
    endtask

    initial begin
        beat_t idle, b;
        idle = '{32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0};
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = 32'd0; in_store_data = 32'd0; in_dest = 5'd0;
        in_reg_write = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        exp_stall = 32'd0;

        //          iv    res           dest   rw    mr    mw    ordy  fl    occ  fwd
        vt[0]  = '{1'b1, 32'h1,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        vt[1]  = '{1'b1, 32'h2,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        vt[2]  = '{1'b1, 32'h3,        5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b1};
        vt[3]  = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[4]  = '{1'b1, 32'hA,        5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[5]  = '{1'b1, 32'hB,        5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[6]  = '{1'b1, 32'hD,        5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[7]  = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[8]  = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[9]  = '{1'b1, 32'hE,        5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[10] = '{1'b1, 32'hF,        5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[11] = '{1'b1, 32'hC,        5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vt[12] = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[13] = '{1'b1, 32'h1234,     5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        vt[14] = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[15] = '{1'b1, 32'h55,       5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[16] = '{1'b1, 32'h66,       5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[17] = '{1'b1, 32'h77,       5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0};
        vt[18] = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};
        vt[19] = '{1'b1, 32'h10,       5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[20] = '{1'b1, 32'h11,       5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[21] = '{1'b1, 32'h12,       5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[22] = '{1'b1, 32'h12,       5'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vt[23] = '{1'b0, 32'h0,        5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0};

        #1;
        check_reset_values("reset_held");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset_released");

        for (int i = 0; i < 24; i++) begin
            drive(vt[i].iv, mk(vt[i]), vt[i].ordy, vt[i].fl);
            check_state($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table_occ", i), 64'(occupancy), 64'(vt[i].exp_occ));
            chk($sformatf("vec%0d_table_fwd", i), 64'(fwd_valid), 64'(vt[i].exp_fwd));
        end

        // Fill both entries, accumulate 7 stall cycles, then reset between edges.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        sb.delete(); exp_stall = 32'd0;
        check_reset_values("reset_pulse");
        b = idle; b.result = 32'h21; b.dest = 5'd9; b.rw = 1'b1;
        drive(1'b1, b, 1'b0, 1'b0);
        b.result = 32'h22;
        drive(1'b1, b, 1'b0, 1'b0);
        repeat (6) drive(1'b0, idle, 1'b0, 1'b0);
        check_state("pre_async");
        chk("pre_async_stall7", 64'(stall_cycles), 64'd7);
        chk("pre_async_occ2", 64'(occupancy), 64'd2);
        #2 reset = 1'b1;
        #1 check_reset_values("async_reset");
        sb.delete(); exp_stall = 32'd0;
        @(negedge clk); reset = 1'b0;

        // Saturation: preload near the top, then keep the head stalled.
        b = idle; b.result = 32'h31;
        drive(1'b1, b, 1'b0, 1'b0);
        force dut.stall_cycles_r = 32'hFFFF_FFFE;
        #1 release dut.stall_cycles_r;
        exp_stall = 32'hFFFF_FFFE;
        chk("sat_preload", 64'(stall_cycles), 64'h0_FFFF_FFFE);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, idle, 1'b0, 1'b0);
            check_state($sformatf("sat%0d", k));
            chk($sformatf("sat%0d_max", k), 64'(stall_cycles), 64'h0_FFFF_FFFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
